// File: rtl/countdown_timer.sv
// Countdown timer mode: load whole seconds with UP/DOWN, run/pause with CENTER,
// decrement once per centisecond and raise ALARM on reaching zero.
module countdown_timer #(
   parameter int TICKS_PER_CS = 10,
   parameter int STEP         = 100,
   parameter int MAX_COUNT    = 9999
) (
   input  logic        CLOCK_1ms,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic        BTN_CENTER,
   input  logic        BTN_UP,
   input  logic        BTN_DOWN,
   output logic [13:0] TIME,
   output logic        RUNNING,
   output logic        ALARM
);

   localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;

   typedef enum logic [1:0] {
      ST_SET,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [13:0]     time_q, time_d;
   logic [13:0]     reload_q, reload_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [3:0]      sync_c_q, sync_c_d;
   logic [3:0]      sync_u_q, sync_u_d;
   logic [3:0]      sync_d_q, sync_d_d;
   logic            running_q, running_d;
   logic            alarm_q, alarm_d;

   logic            press_c, press_u, press_d;
   logic            tick;

   // Sums and differences are formed one bit wider so saturation sees the true result.
   function automatic logic [13:0] sat_add(input logic [13:0] t);
      logic [14:0] s;
      s = {1'b0, t} + 15'(STEP);
      if (s > 15'(MAX_COUNT)) return 14'(MAX_COUNT);
      return s[13:0];
   endfunction

   function automatic logic [13:0] sat_sub(input logic [13:0] t);
      logic [14:0] s;
      if ({1'b0, t} >= 15'(STEP)) s = {1'b0, t} - 15'(STEP);
      else s = '0;
      return s[13:0];
   endfunction

   always_comb begin
      sync_c_d = {sync_c_q[2:0], BTN_CENTER};
      sync_u_d = {sync_u_q[2:0], BTN_UP};
      sync_d_d = {sync_d_q[2:0], BTN_DOWN};
      press_c  = ENABLE && (sync_c_q[3:2] == 2'b01);
      press_u  = ENABLE && (sync_u_q[3:2] == 2'b01);
      press_d  = ENABLE && (sync_d_q[3:2] == 2'b01);
      tick     = (state_q == ST_RUN) && (presc_q == PW'(TICKS_PER_CS - 1));
   end

   always_comb begin
      state_d  = state_q;
      time_d   = time_q;
      reload_d = reload_q;
      presc_d  = presc_q;

      case (state_q)
         ST_SET: begin
            if (press_c) begin
               if (time_q != '0) begin
                  reload_d = time_q;
                  state_d  = ST_RUN;
               end
            end else if (press_u && !press_d) begin
               time_d = sat_add(time_q);
            end else if (press_d && !press_u) begin
               time_d = sat_sub(time_q);
            end
         end
         ST_RUN: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            // Reaching zero wins over a simultaneous pause request.
            if (tick && time_q == 14'd1) begin
               time_d  = '0;
               state_d = ST_DONE;
            end else begin
               if (tick) time_d = time_q - 14'd1;
               if (press_c) state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (press_c) begin
               state_d = ST_RUN;
            end else if (press_d) begin
               time_d  = '0;
               state_d = ST_SET;
            end
         end
         ST_DONE: begin
            time_d = '0;
            if (press_c) begin
               time_d  = reload_q;
               state_d = ST_SET;
            end
         end
         default: state_d = ST_SET;
      endcase

      if (state_d == ST_SET) presc_d = '0;

      running_d = (state_d == ST_RUN);
      alarm_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge CLOCK_1ms or posedge RESET) begin
      if (RESET) begin
         state_q   <= ST_SET;
         time_q    <= '0;
         reload_q  <= '0;
         presc_q   <= '0;
         sync_c_q  <= '0;
         sync_u_q  <= '0;
         sync_d_q  <= '0;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         reload_q  <= reload_d;
         presc_q   <= presc_d;
         sync_c_q  <= sync_c_d;
         sync_u_q  <= sync_u_d;
         sync_d_q  <= sync_d_d;
         running_q <= running_d;
         alarm_q   <= alarm_d;
      end
   end

   assign TIME    = time_q;
   assign RUNNING = running_q;
   assign ALARM   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: loading, saturation, run/pause, alarm,
// enable gating and asynchronous reset, with hand-computed expected values.
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        btn_c, btn_u, btn_d;
   logic [13:0] time_o;
   logic        running, alarm;

   int n_checks = 0;
   int n_fail   = 0;

   countdown_timer dut (
      .CLOCK_1ms (clk),
      .RESET     (rst),
      .ENABLE    (enable),
      .BTN_CENTER(btn_c),
      .BTN_UP    (btn_u),
      .BTN_DOWN  (btn_d),
      .TIME      (time_o),
      .RUNNING   (running),
      .ALARM     (alarm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Action lands on the 6th clock edge after the call point; returns 1 ns after it.
   task automatic press(input logic [2:0] m);
      @(negedge clk);
      repeat (2) @(negedge clk);
      btn_c = m[2];
      btn_u = m[1];
      btn_d = m[0];
      repeat (4) @(posedge clk);
      #1;
      btn_c = 1'b0;
      btn_u = 1'b0;
      btn_d = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   localparam logic [2:0] C = 3'b100, U = 3'b010, D = 3'b001;

   initial begin
      rst = 1'b1; enable = 1'b1; btn_c = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
      #1;
      check("reset_time", 32'(time_o), 0);
      check("reset_running", 32'(running), 0);
      check("reset_alarm", 32'(alarm), 0);
      do_reset();

      // Held button gives a single step
      @(negedge clk);
      btn_u = 1'b1;
      adv(20);
      check("held_up_once", 32'(time_o), 100);
      btn_u = 1'b0;

      // Saturation
      for (int i = 0; i < 98; i++) press(U);
      check("up_9900", 32'(time_o), 9900);
      press(U);
      check("up_sat_9999", 32'(time_o), 9999);
      press(U | D);
      check("up_down_same_cycle", 32'(time_o), 9999);
      press(D);
      check("down_9899", 32'(time_o), 9899);
      for (int i = 0; i < 98; i++) press(D);
      check("down_99", 32'(time_o), 99);
      press(D);
      check("down_below_step", 32'(time_o), 0);
      press(D);
      check("down_at_zero", 32'(time_o), 0);
      press(C);
      check("center_zero_running", 32'(running), 0);
      check("center_zero_time", 32'(time_o), 0);

      // Basic countdown from 300
      for (int i = 0; i < 3; i++) press(U);
      check("load_300", 32'(time_o), 300);
      check("load_running", 32'(running), 0);
      press(C);
      check("start_running", 32'(running), 1);
      check("start_time", 32'(time_o), 300);
      adv(9);
      check("before_first_tick", 32'(time_o), 300);
      adv(1);
      check("first_tick", 32'(time_o), 299);
      adv(2989);
      check("at_one", 32'(time_o), 1);
      check("at_one_alarm", 32'(alarm), 0);
      adv(1);
      check("expired_time", 32'(time_o), 0);
      check("expired_alarm", 32'(alarm), 1);
      check("expired_running", 32'(running), 0);
      press(U);
      check("done_up_ignored", 32'(time_o), 0);
      press(D);
      check("done_down_ignored", 32'(time_o), 0);
      check("done_alarm_held", 32'(alarm), 1);
      press(C);
      check("reload_time", 32'(time_o), 300);
      check("reload_alarm", 32'(alarm), 0);
      check("reload_running", 32'(running), 0);

      // Pause at 505 clocks, resume with held prescaler (5 of 10 used)
      press(C);
      adv(499);
      press(C);
      check("pause_time", 32'(time_o), 250);
      check("pause_running", 32'(running), 0);
      adv(2000);
      check("pause_frozen", 32'(time_o), 250);
      press(C);
      check("resume_running", 32'(running), 1);
      adv(4);
      check("resume_pre_tick", 32'(time_o), 250);
      adv(1);
      check("resume_tick", 32'(time_o), 249);
      press(C);
      check("pause2_running", 32'(running), 0);
      press(D);
      check("pause_clear_time", 32'(time_o), 0);
      check("pause_clear_running", 32'(running), 0);
      press(U);
      check("back_in_set", 32'(time_o), 100);

      // CENTER on the final tick: DONE beats PAUSE
      press(C);
      adv(994);
      press(C);
      check("collide_alarm", 32'(alarm), 1);
      check("collide_running", 32'(running), 0);
      check("collide_time", 32'(time_o), 0);
      adv(20);
      check("collide_alarm_stays", 32'(alarm), 1);
      press(C);
      check("collide_reload", 32'(time_o), 100);
      check("collide_reload_alarm", 32'(alarm), 0);

      // ENABLE gating
      press(U);
      check("load_200", 32'(time_o), 200);
      press(C | U);
      check("center_priority_run", 32'(running), 1);
      check("center_priority_time", 32'(time_o), 200);
      enable = 1'b0;
      press(C);
      check("gated_center", 32'(running), 1);
      press(U);
      check("gated_up", 32'(time_o), 199);
      adv(1987);
      check("gated_at_one", 32'(time_o), 1);
      adv(1);
      check("gated_expired_time", 32'(time_o), 0);
      check("gated_expired_alarm", 32'(alarm), 1);
      enable = 1'b1;
      press(C);
      check("gated_reload", 32'(time_o), 200);

      // Asynchronous reset mid-run, buttons held across release
      press(C);
      adv(50);
      check("run_before_reset", 32'(running), 1);
      #3;
      rst = 1'b1;
      #1;
      check("async_time", 32'(time_o), 0);
      check("async_running", 32'(running), 0);
      check("async_alarm", 32'(alarm), 0);
      btn_c = 1'b1;
      btn_u = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      adv(10);
      check("held_release_time", 32'(time_o), 0);
      check("held_release_running", 32'(running), 0);
      btn_c = 1'b0;
      btn_u = 1'b0;
      press(U);
      check("post_reset_up", 32'(time_o), 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
